// File: rtl/filter_addr_sequencer_if.sv
// Control, configuration and address handshake bundle for filter_addr_sequencer.
// The master side drives start/config/ready; the slave side (the sequencer) returns addresses and status.
interface filter_addr_sequencer_if #(
    parameter int FILTER_SPAD_DEPTH = 225,
    parameter int CONFIG_BIT        = 5,
    parameter int CH_BIT            = 4,
    parameter int F_BIT             = 4
);
    localparam int AW = $clog2(FILTER_SPAD_DEPTH);

    logic                  start;
    logic                  clear;
    logic                  mode;
    logic [CONFIG_BIT-1:0] filter_size;
    logic [CH_BIT-1:0]     num_channels;
    logic [F_BIT-1:0]      num_filters;
    logic [AW-1:0]         filter_stride;
    logic                  addr_ready;
    logic                  addr_valid;
    logic [AW-1:0]         filter_read_address;
    logic [AW-1:0]         filter_base_address;
    logic                  last;
    logic                  busy;
    logic                  done;
    logic                  err_range;

    modport master (
        output start, clear, mode, filter_size, num_channels, num_filters, filter_stride, addr_ready,
        input  addr_valid, filter_read_address, filter_base_address, last, busy, done, err_range
    );

    modport slave (
        input  start, clear, mode, filter_size, num_channels, num_filters, filter_stride, addr_ready,
        output addr_valid, filter_read_address, filter_base_address, last, busy, done, err_range
    );
endinterface

// File: rtl/filter_addr_sequencer.sv
// Generates filter scratchpad read addresses f*stride + c*size + k over a latched
// configuration, in filter-major or channel-major order, with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; configuration inputs are not observed
// RUN   | addr_valid high, counters advance on each handshake
// DONE  | one-cycle done pulse, then back to IDLE
module filter_addr_sequencer #(
    parameter int FILTER_SPAD_DEPTH = 225,
    parameter int CONFIG_BIT        = 5,
    parameter int CH_BIT            = 4,
    parameter int F_BIT             = 4
) (
    input logic                    clk,
    input logic                    rst,
    filter_addr_sequencer_if.slave bus
);
    localparam int AW = $clog2(FILTER_SPAD_DEPTH);
    localparam int WW = AW + CH_BIT + F_BIT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CONFIG_BIT-1:0] k_q, k_d;
    logic [CH_BIT-1:0]     c_q, c_d;
    logic [F_BIT-1:0]      f_q, f_d;
    logic                  mode_q, mode_d;
    logic [CONFIG_BIT-1:0] fs_q, fs_d;
    logic [CH_BIT-1:0]     ch_q, ch_d;
    logic [F_BIT-1:0]      nf_q, nf_d;
    logic [AW-1:0]         stride_q, stride_d;
    logic                  err_q, err_d;

    logic [WW-1:0] base_wide;
    logic [WW-1:0] addr_wide;
    logic          k_last;
    logic          c_last;
    logic          f_last;
    logic          in_run;
    logic          seq_last;
    logic          cfg_zero;
    logic          out_of_range;

    // Wide arithmetic so range/overflow can be judged before truncation to AW bits.
    always_comb begin
        base_wide = WW'(f_q) * WW'(stride_q);
        addr_wide = base_wide + WW'(c_q) * WW'(fs_q) + WW'(k_q);
    end

    always_comb begin
        in_run       = (state_q == RUN);
        k_last       = (k_q == fs_q - CONFIG_BIT'(1));
        c_last       = (c_q == ch_q - CH_BIT'(1));
        f_last       = (f_q == nf_q - F_BIT'(1));
        seq_last     = in_run && k_last && c_last && f_last;
        cfg_zero     = (bus.filter_size == '0) || (bus.num_channels == '0) || (bus.num_filters == '0);
        out_of_range = (addr_wide >= WW'(FILTER_SPAD_DEPTH))
                       || (addr_wide[WW-1:AW] != '0)
                       || (base_wide[WW-1:AW] != '0);
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        c_d      = c_q;
        f_d      = f_q;
        mode_d   = mode_q;
        fs_d     = fs_q;
        ch_d     = ch_q;
        nf_d     = nf_q;
        stride_d = stride_q;
        err_d    = err_q;

        if (bus.clear) begin
            state_d = IDLE;
            k_d     = '0;
            c_d     = '0;
            f_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mode_d   = bus.mode;
                        fs_d     = bus.filter_size;
                        ch_d     = bus.num_channels;
                        nf_d     = bus.num_filters;
                        stride_d = bus.filter_stride;
                        k_d      = '0;
                        c_d      = '0;
                        f_d      = '0;
                        err_d    = 1'b0;
                        state_d  = cfg_zero ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (bus.addr_ready) begin
                        if (seq_last) begin
                            state_d = DONE;
                            k_d     = '0;
                            c_d     = '0;
                            f_d     = '0;
                        end else begin
                            k_d = k_last ? '0 : k_q + CONFIG_BIT'(1);
                            // The k wrap carries into the middle counter selected by mode.
                            if (k_last && !mode_q) begin
                                c_d = c_last ? '0 : c_q + CH_BIT'(1);
                                if (c_last) begin
                                    f_d = f_q + F_BIT'(1);
                                end
                            end else if (k_last) begin
                                f_d = f_last ? '0 : f_q + F_BIT'(1);
                                if (f_last) begin
                                    c_d = c_q + CH_BIT'(1);
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (in_run && out_of_range) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            c_q      <= '0;
            f_q      <= '0;
            mode_q   <= 1'b0;
            fs_q     <= '0;
            ch_q     <= '0;
            nf_q     <= '0;
            stride_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            c_q      <= c_d;
            f_q      <= f_d;
            mode_q   <= mode_d;
            fs_q     <= fs_d;
            ch_q     <= ch_d;
            nf_q     <= nf_d;
            stride_q <= stride_d;
            err_q    <= err_d;
        end
    end

    assign bus.addr_valid          = in_run;
    assign bus.filter_read_address = addr_wide[AW-1:0];
    assign bus.filter_base_address = base_wide[AW-1:0];
    assign bus.last                = seq_last;
    assign bus.busy                = (state_q != IDLE);
    assign bus.done                = (state_q == DONE);
    assign bus.err_range           = err_q;
endmodule

// File: tb/tb_filter_addr_sequencer.sv
// Self-checking bench for filter_addr_sequencer: directed vectors plus randomized
// configurations compared against a nested-loop address model.
module tb_filter_addr_sequencer;
    localparam int DEPTH      = 225;
    localparam int CONFIG_BIT = 5;
    localparam int CH_BIT     = 4;
    localparam int F_BIT      = 4;
    localparam int AW         = $clog2(DEPTH);
    localparam int AMOD       = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    filter_addr_sequencer_if #(
        .FILTER_SPAD_DEPTH(DEPTH), .CONFIG_BIT(CONFIG_BIT), .CH_BIT(CH_BIT), .F_BIT(F_BIT)
    ) bus ();

    filter_addr_sequencer #(
        .FILTER_SPAD_DEPTH(DEPTH), .CONFIG_BIT(CONFIG_BIT), .CH_BIT(CH_BIT), .F_BIT(F_BIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // observations from the last run_seq
    int q_addr[$], q_base[$], q_last[$], q_err[$], q_stall[$];
    int done_count, done_cycle, valid_seen, err_first, err_final, busy_after;
    bit timed_out;
    // reference model results
    int e_addr[$], e_base[$], e_last[$], e_err[$];
    int e_any_err;

    task automatic build_model(input bit m, input int fs, input int ch, input int nf, input int stride);
        int a;
        int seen_err;
        e_addr.delete(); e_base.delete(); e_last.delete(); e_err.delete();
        seen_err = 0;
        for (int o = 0; o < (m ? ch : nf); o++)
            for (int mid = 0; mid < (m ? nf : ch); mid++)
                for (int k = 0; k < fs; k++) begin
                    int f, c;
                    f = m ? mid : o;
                    c = m ? o : mid;
                    a = f * stride + c * fs + k;
                    e_addr.push_back(a % AMOD);
                    e_base.push_back((f * stride) % AMOD);
                    e_last.push_back(0);
                    e_err.push_back(seen_err);
                    if (a >= DEPTH) seen_err = 1;
                end
        if (e_last.size() > 0) e_last[e_last.size()-1] = 1;
        e_any_err = seen_err;
    endtask

    // Drives one sequence and records what the DUT presents; comparisons are done by callers.
    task automatic run_seq(input bit m, input int fs, input int ch, input int nf, input int stride,
                           input int stall_idx, input int stall_len, input bit rnd);
        int  hs, stalled;
        bit  prev_valid, finished;
        q_addr.delete(); q_base.delete(); q_last.delete(); q_err.delete(); q_stall.delete();
        done_count = 0; done_cycle = -1; valid_seen = 0; err_first = -1; err_final = -1; busy_after = -1;
        timed_out = 0;
        bus.mode = m;
        bus.filter_size = CONFIG_BIT'(fs);
        bus.num_channels = CH_BIT'(ch);
        bus.num_filters = F_BIT'(nf);
        bus.filter_stride = AW'(stride);
        bus.clear = 1'b0;
        bus.addr_ready = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        hs = 0; stalled = 0; prev_valid = 0; finished = 0;
        for (int cyc = 1; cyc <= 2000 && !finished; cyc++) begin
            bus.mode = 1'($urandom);
            bus.filter_size = CONFIG_BIT'($urandom);
            bus.num_channels = CH_BIT'($urandom);
            bus.num_filters = F_BIT'($urandom);
            bus.filter_stride = AW'($urandom);
            if (rnd) bus.addr_ready = ($urandom_range(0, 2) != 0);
            else if (hs == stall_idx && stalled < stall_len) bus.addr_ready = 1'b0;
            else bus.addr_ready = 1'b1;
            bus.start = prev_valid && rnd && ($urandom_range(0, 3) == 0);
            #1;
            if (cyc == 1) err_first = int'(bus.err_range);
            if (bus.addr_valid) begin
                valid_seen++;
                if (bus.addr_ready) begin
                    q_addr.push_back(int'(bus.filter_read_address));
                    q_base.push_back(int'(bus.filter_base_address));
                    q_last.push_back(int'(bus.last));
                    q_err.push_back(int'(bus.err_range));
                    hs++;
                end else begin
                    q_stall.push_back(int'(bus.filter_read_address));
                    stalled++;
                end
            end
            if (bus.done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (done_cycle >= 0 && cyc == done_cycle + 1) begin
                err_final = int'(bus.err_range);
                busy_after = int'(bus.busy);
                finished = 1;
            end
            prev_valid = bus.addr_valid;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.addr_ready = 1'b0;
        if (!finished) timed_out = 1;
    endtask

    task automatic test_reset();
        int    obs[7];
        string nm[7] = '{"valid", "read_addr", "base_addr", "last", "busy", "done", "err_range"};
        rst = 1'b1;
        bus.start = 1'b1; bus.clear = 1'b0; bus.mode = 1'b1; bus.addr_ready = 1'b1;
        bus.filter_size = 5'd3; bus.num_channels = 4'd2; bus.num_filters = 4'd2; bus.filter_stride = 8'd8;
        repeat (3) @(posedge clk);
        #1;
        obs = '{int'(bus.addr_valid), int'(bus.filter_read_address), int'(bus.filter_base_address),
                int'(bus.last), int'(bus.busy), int'(bus.done), int'(bus.err_range)};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs[i] !== 0) begin
                failures++;
                $display("FAIL reset_%s got=%0d want=0", nm[i], obs[i]);
            end
        end
        bus.start = 1'b0;
        bus.addr_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_order(input bit m, input int stall_idx, input int stall_len);
        int exp_a[12];
        int n;
        if (!m) exp_a = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13};
        else    exp_a = '{0, 1, 2, 8, 9, 10, 3, 4, 5, 11, 12, 13};
        run_seq(m, 3, 2, 2, 8, stall_idx, stall_len, 0);
        checks++;
        if (timed_out) begin failures++; $display("FAIL order_m%0d_timeout got=no_done want=done", m); end
        checks++;
        if (q_addr.size() !== 12) begin
            failures++; $display("FAIL order_m%0d_count got=%0d want=12", m, q_addr.size());
        end
        n = (q_addr.size() < 12) ? q_addr.size() : 12;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (q_addr[i] !== exp_a[i]) begin
                failures++; $display("FAIL order_m%0d_addr[%0d] got=%0d want=%0d", m, i, q_addr[i], exp_a[i]);
            end
            checks++;
            if (q_base[i] !== ((exp_a[i] >= 8) ? 8 : 0)) begin
                failures++; $display("FAIL order_m%0d_base[%0d] got=%0d want=%0d", m, i, q_base[i], (exp_a[i] >= 8) ? 8 : 0);
            end
            checks++;
            if (q_last[i] !== ((i == 11) ? 1 : 0)) begin
                failures++; $display("FAIL order_m%0d_last[%0d] got=%0d want=%0d", m, i, q_last[i], (i == 11) ? 1 : 0);
            end
        end
        checks++;
        if (done_cycle !== 13 + stall_len) begin
            failures++; $display("FAIL order_m%0d_done_cycle got=%0d want=%0d", m, done_cycle, 13 + stall_len);
        end
        checks++;
        if (done_count !== 1) begin failures++; $display("FAIL order_m%0d_done_width got=%0d want=1", m, done_count); end
        checks++;
        if (busy_after !== 0) begin failures++; $display("FAIL order_m%0d_busy_after got=%0d want=0", m, busy_after); end
        if (stall_len > 0) begin
            checks++;
            if (q_stall.size() !== stall_len) begin
                failures++; $display("FAIL stall_cycles got=%0d want=%0d", q_stall.size(), stall_len);
            end
            foreach (q_stall[i]) begin
                checks++;
                if (q_stall[i] !== exp_a[stall_idx]) begin
                    failures++; $display("FAIL stall_hold[%0d] got=%0d want=%0d", i, q_stall[i], exp_a[stall_idx]);
                end
            end
        end
    endtask

    task automatic test_zero_count();
        int cfg[3][3] = '{'{3, 0, 2}, '{0, 2, 2}, '{3, 2, 0}};
        foreach (cfg[v]) begin
            run_seq(1'($urandom), cfg[v][0], cfg[v][1], cfg[v][2], 8, -1, 0, 0);
            checks++;
            if (timed_out) begin failures++; $display("FAIL zero%0d_timeout got=no_done want=done", v); end
            checks++;
            if (valid_seen !== 0) begin failures++; $display("FAIL zero%0d_valid got=%0d want=0", v, valid_seen); end
            checks++;
            if (done_cycle !== 1) begin failures++; $display("FAIL zero%0d_done_cycle got=%0d want=1", v, done_cycle); end
            checks++;
            if (done_count !== 1) begin failures++; $display("FAIL zero%0d_done_width got=%0d want=1", v, done_count); end
        end
    endtask

    task automatic test_err_range();
        build_model(0, 15, 1, 2, 220);
        run_seq(0, 15, 1, 2, 220, -1, 0, 0);
        checks++;
        if (timed_out) begin failures++; $display("FAIL err_timeout got=no_done want=done"); end
        checks++;
        if (q_addr.size() !== e_addr.size()) begin
            failures++; $display("FAIL err_count got=%0d want=%0d", q_addr.size(), e_addr.size());
        end
        for (int i = 0; i < q_addr.size() && i < e_addr.size(); i++) begin
            checks++;
            if (q_addr[i] !== e_addr[i] || q_err[i] !== e_err[i]) begin
                failures++;
                $display("FAIL err_step[%0d] got addr=%0d err=%0d want addr=%0d err=%0d", i, q_addr[i], q_err[i], e_addr[i], e_err[i]);
            end
        end
        checks++;
        if (err_final !== 1) begin failures++; $display("FAIL err_held_after_done got=%0d want=1", err_final); end
    endtask

    task automatic test_abort(input bit use_rst);
        int    obs[7];
        int    want_err;
        bit    seen_done, seen_busy;
        string nm[7] = '{"valid", "read_addr", "base_addr", "last", "busy", "done", "err_range"};
        want_err = use_rst ? 0 : 1;
        bus.mode = 1'b0; bus.filter_size = 5'd15; bus.num_channels = 4'd1; bus.num_filters = 4'd2;
        bus.filter_stride = 8'd220; bus.addr_ready = 1'b1; bus.clear = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 22; cyc++) begin @(posedge clk); #1; end
        checks++;
        if (bus.busy !== 1'b1 || bus.err_range !== 1'b1) begin
            failures++; $display("FAIL abort%0d_pre got busy=%0b err=%0b want busy=1 err=1", use_rst, bus.busy, bus.err_range);
        end
        if (use_rst) rst = 1'b1; else bus.clear = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.clear = 1'b0; bus.start = 1'b0;
        obs = '{int'(bus.addr_valid), int'(bus.filter_read_address), int'(bus.filter_base_address),
                int'(bus.last), int'(bus.busy), int'(bus.done), int'(bus.err_range)};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs[i] !== ((i == 6) ? want_err : 0)) begin
                failures++; $display("FAIL abort%0d_%s got=%0d want=%0d", use_rst, nm[i], obs[i], (i == 6) ? want_err : 0);
            end
        end
        seen_done = 0; seen_busy = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1;
            if (bus.busy) seen_busy = 1;
        end
        checks++;
        if (seen_done || seen_busy) begin
            failures++; $display("FAIL abort%0d_after got done=%0b busy=%0b want done=0 busy=0", use_rst, seen_done, seen_busy);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            bit m;
            int fs, ch, nf, stride;
            m = 1'($urandom);
            fs = $urandom_range(1, 5);
            ch = $urandom_range(1, 3);
            nf = $urandom_range(1, 3);
            stride = $urandom_range(0, AMOD - 1);
            build_model(m, fs, ch, nf, stride);
            run_seq(m, fs, ch, nf, stride, -1, 0, 1);
            checks++;
            if (timed_out || q_addr.size() !== e_addr.size()) begin
                failures++;
                $display("FAIL rand%0d_count got=%0d want=%0d timeout=%0b", t, q_addr.size(), e_addr.size(), timed_out);
            end
            for (int i = 0; i < q_addr.size() && i < e_addr.size(); i++) begin
                checks++;
                if (q_addr[i] !== e_addr[i] || q_base[i] !== e_base[i] || q_last[i] !== e_last[i]) begin
                    failures++;
                    $display("FAIL rand%0d_step[%0d] got a=%0d b=%0d l=%0d want a=%0d b=%0d l=%0d",
                             t, i, q_addr[i], q_base[i], q_last[i], e_addr[i], e_base[i], e_last[i]);
                end
            end
            checks++;
            if (err_first !== 0 || err_final !== e_any_err || done_count !== 1) begin
                failures++;
                $display("FAIL rand%0d_status got err0=%0d errN=%0d dones=%0d want err0=0 errN=%0d dones=1",
                         t, err_first, err_final, done_count, e_any_err);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=stuck want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0; bus.clear = 1'b0; bus.mode = 1'b0; bus.addr_ready = 1'b0;
        bus.filter_size = '0; bus.num_channels = '0; bus.num_filters = '0; bus.filter_stride = '0;
        test_reset();
        test_order(1'b0, -1, 0);
        test_order(1'b1, -1, 0);
        test_order(1'b0, 1, 3);
        test_zero_count();
        test_err_range();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
